// File: rtl/flip_writer.sv
// Walks a ray from a placed stone and writes the mover's colour over each flipped cell.
// Optional FLIP_BOUNDS_CHECK_EN aborts the ray (err with done) when it leaves the board.
module flip_writer #(
  parameter int BOARD_DIM = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [7:0] origin,
  input  logic [2:0] dir,
  input  logic [2:0] count,
  input  logic       color,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] wr_addr,
  output logic [1:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  localparam logic [4:0] DIM = 5'(BOARD_DIM);

  state_t     state_q, state_d;
  logic [2:0] dir_q, dir_d;
  logic [2:0] rem_q, rem_d;
  logic [7:0] cur_q, cur_d;
  logic       color_q, color_d;
  logic       err_q, err_d;
  logic       oob;

  // y lives in the high nibble, so negative steps are two's-complement bytes
  function automatic logic [7:0] step(input logic [2:0] d);
    logic [7:0] s;
    s = 8'h00;
    unique case (d)
      3'd0: s = 8'h01;
      3'd1: s = 8'h11;
      3'd2: s = 8'h10;
      3'd3: s = 8'h0f;
      3'd4: s = 8'hff;
      3'd5: s = 8'hef;
      3'd6: s = 8'hf0;
      3'd7: s = 8'hf1;
    endcase
    return s;
  endfunction

`ifdef FLIP_BOUNDS_CHECK_EN
  assign oob = ({1'b0, cur_q[3:0]} >= DIM)
            || ({1'b0, cur_q[7:4]} >= DIM);
  assign err = (state_q == DONE) && err_q;
`else
  logic unused_cfg;
  assign oob        = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = ^{DIM, err_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= '0;
      rem_q   <= '0;
      cur_q   <= '0;
      color_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      cur_q   <= cur_d;
      color_q <= color_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    cur_d   = cur_q;
    color_d = color_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          dir_d   = dir;
          color_d = color;
          rem_d   = count;
          cur_d   = origin + step(dir);
          err_d   = 1'b0;
          state_d = (count != 3'd0) ? WRITE : DONE;
        end
      end
      WRITE: begin
        if (oob) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wr_ready) begin
          rem_d = rem_q - 3'd1;
          cur_d = cur_q + step(dir_q);
          if (rem_q == 3'd1) state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign wr_valid    = (state_q == WRITE) && !oob;
  assign wr_addr     = cur_q;
  assign wr_data     = color_q ? 2'b10 : 2'b01;

endmodule

// File: tb/tb_flip_writer.sv
// Directed bench for flip_writer: basic rays, stalls, count 0, bounds and async reset.
// Expected vectors are hand-computed from the ray stepping rules.
module tb_flip_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] origin;
  logic [2:0] dir;
  logic [2:0] count;
  logic       color;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [1:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;

  int n_chk = 0;
  int n_fail = 0;

  flip_writer #(.BOARD_DIM(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .origin(origin),
    .dir(dir),
    .count(count),
    .color(color),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [7:0] o, input logic [2:0] d,
                     input logic [2:0] c, input logic col);
    start_valid = 1'b1;
    origin = o;
    dir = d;
    count = c;
    color = col;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_valid = 1'b0;
    origin = '0;
    dir = '0;
    count = '0;
    color = 1'b0;
    wr_ready = 1'b0;
    #12;
    n_chk++;
    if ({wr_valid, busy, done, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 0000",
               {wr_valid, busy, done, err});
    end
    rst_n = 1'b1;
    tick();
    n_chk++;
    if ({start_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 10", {start_ready, busy});
    end
  endtask

  task automatic test_basic();
    wr_ready = 1'b1;
    n_chk++;
    if (start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: got %b want 1", start_ready);
    end
    req(8'h33, 3'd0, 3'd2, 1'b0);
    n_chk++;
    if ({busy, wr_valid, wr_addr, wr_data} !== {1'b1, 1'b1, 8'h34, 2'b01}) begin
      n_fail++;
      $display("FAIL basic_w0: got %h want %h",
               {busy, wr_valid, wr_addr, wr_data}, {1'b1, 1'b1, 8'h34, 2'b01});
    end
    tick();
    n_chk++;
    if ({busy, wr_valid, wr_addr, wr_data} !== {1'b1, 1'b1, 8'h35, 2'b01}) begin
      n_fail++;
      $display("FAIL basic_w1: got %h want %h",
               {busy, wr_valid, wr_addr, wr_data}, {1'b1, 1'b1, 8'h35, 2'b01});
    end
    tick();
    n_chk++;
    if ({wr_valid, done, start_ready, err} !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_done: got %b want 0100",
               {wr_valid, done, start_ready, err});
    end
    tick();
    n_chk++;
    if ({done, start_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL basic_idle: got %b want 010", {done, start_ready, busy});
    end
  endtask

  task automatic test_diag_busy_ignore();
    logic [7:0] exp_a [3] = '{8'h44, 8'h33, 8'h22};
    wr_ready = 1'b1;
    req(8'h55, 3'd5, 3'd3, 1'b1);
    start_valid = 1'b1;
    origin = 8'h00;
    dir = 3'd0;
    count = 3'd7;
    color = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, exp_a[i], 2'b10}) begin
        n_fail++;
        $display("FAIL diag_w%0d: got %h want %h", i,
                 {wr_valid, wr_addr, wr_data}, {1'b1, exp_a[i], 2'b10});
      end
      tick();
    end
    n_chk++;
    if ({wr_valid, done, start_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL diag_done: got %b want 010", {wr_valid, done, start_ready});
    end
    start_valid = 1'b0;
    tick();
    n_chk++;
    if ({wr_valid, done, busy, start_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL diag_idle: got %b want 0001",
               {wr_valid, done, busy, start_ready});
    end
  endtask

  task automatic test_stall();
    wr_ready = 1'b0;
    req(8'h20, 3'd2, 3'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({wr_valid, wr_addr, wr_data, done} !== {1'b1, 8'h30, 2'b01, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_c%0d: got %h want %h", i,
                 {wr_valid, wr_addr, wr_data, done}, {1'b1, 8'h30, 2'b01, 1'b0});
      end
      tick();
    end
    wr_ready = 1'b1;
    n_chk++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h30, 2'b01}) begin
      n_fail++;
      $display("FAIL stall_c4: got %h want %h",
               {wr_valid, wr_addr, wr_data}, {1'b1, 8'h30, 2'b01});
    end
    tick();
    n_chk++;
    if ({wr_valid, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_done: got %b want 01", {wr_valid, done});
    end
    tick();
  endtask

  task automatic test_zero();
    wr_ready = 1'b1;
    req(8'h44, 3'd1, 3'd0, 1'b1);
    n_chk++;
    if ({wr_valid, done, start_ready, busy} !== 4'b0101) begin
      n_fail++;
      $display("FAIL zero_done: got %b want 0101",
               {wr_valid, done, start_ready, busy});
    end
    tick();
    n_chk++;
    if ({wr_valid, done, start_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL zero_idle: got %b want 001", {wr_valid, done, start_ready});
    end
  endtask

  task automatic test_bounds();
    wr_ready = 1'b1;
    req(8'h06, 3'd0, 3'd3, 1'b1);
    n_chk++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h07, 2'b10}) begin
      n_fail++;
      $display("FAIL bnd_w0: got %h want %h",
               {wr_valid, wr_addr, wr_data}, {1'b1, 8'h07, 2'b10});
    end
    tick();
`ifdef FLIP_BOUNDS_CHECK_EN
    n_chk++;
    if ({wr_valid, done, err} !== 3'b011) begin
      n_fail++;
      $display("FAIL bnd_abort: got %b want 011", {wr_valid, done, err});
    end
    tick();
    n_chk++;
    if ({done, err, start_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL bnd_idle: got %b want 001", {done, err, start_ready});
    end
`else
    n_chk++;
    if ({wr_valid, wr_addr, err} !== {1'b1, 8'h08, 1'b0}) begin
      n_fail++;
      $display("FAIL bnd_w1: got %h want %h",
               {wr_valid, wr_addr, err}, {1'b1, 8'h08, 1'b0});
    end
    tick();
    n_chk++;
    if ({wr_valid, wr_addr, err} !== {1'b1, 8'h09, 1'b0}) begin
      n_fail++;
      $display("FAIL bnd_w2: got %h want %h",
               {wr_valid, wr_addr, err}, {1'b1, 8'h09, 1'b0});
    end
    tick();
    n_chk++;
    if ({wr_valid, done, err} !== 3'b010) begin
      n_fail++;
      $display("FAIL bnd_done: got %b want 010", {wr_valid, done, err});
    end
    tick();
    req(8'h00, 3'd5, 3'd1, 1'b0);
    n_chk++;
    if ({wr_valid, wr_addr} !== {1'b1, 8'hef}) begin
      n_fail++;
      $display("FAIL wrap_w0: got %h want %h", {wr_valid, wr_addr}, {1'b1, 8'hef});
    end
    tick();
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    wr_ready = 1'b1;
    req(8'h33, 3'd0, 3'd2, 1'b0);
    wr_ready = 1'b0;
    n_chk++;
    if (wr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %b want 1", wr_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({wr_valid, busy, done, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b want 0000",
               {wr_valid, busy, done, err});
    end
    #2;
    rst_n = 1'b1;
    tick();
    n_chk++;
    if ({start_ready, wr_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_ready: got %b want 10", {start_ready, wr_valid});
    end
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_diag_busy_ignore();
    test_stall();
    test_zero();
    test_bounds();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
